// File: rtl/change_pkg.sv
// rtl/change_pkg.sv - shared state enum, ch code constants and ch-to-coins mapping
package change_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_GAP   = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  localparam logic [1:0] CH_NONE  = 2'b00;
  localparam logic [1:0] CH_ONE   = 2'b01;
  localparam logic [1:0] CH_TWO   = 2'b10;
  localparam logic [1:0] CH_THREE = 2'b11;

  // Number of coins requested by one ch code
  function automatic logic [1:0] ch_to_coins(input logic [1:0] code);
    logic [1:0] n;
    case (code)
      CH_ONE:   n = 2'd1;
      CH_TWO:   n = 2'd2;
      CH_THREE: n = 2'd3;
      default:  n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// rtl/cycle_timer.sv - loadable down-counter with done flag (gap and ack-timeout timing)
module cycle_timer #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load wins over count; counting stops at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register, cleared by reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - coin change dispenser FSM; optional ack timeout via CHANGE_TIMEOUT_EN
module change_dispenser
  import change_pkg::*;
#(
  parameter int MAX_OWED    = 15,
  parameter int GAP_CYCLES  = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       R,
  input  logic [1:0] ch,
  output logic       coin_req,
  input  logic       coin_ack,
  input  logic       hopper_empty,
  input  logic       fault_clr,
  output logic [3:0] owed,
  output logic       busy,
  output logic       fault,
  output logic       ovf
);

  // Timer is loaded with (cycles - 1) and finishes when it reads zero
  localparam int TMAX = (GAP_CYCLES > ACK_TIMEOUT) ? GAP_CYCLES : ACK_TIMEOUT;
  localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX);
  localparam logic [TW-1:0] GAP_LOAD = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
`ifdef CHANGE_TIMEOUT_EN
  localparam logic [TW-1:0] ACK_LOAD = TW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
`endif

  state_e         state_q;
  state_e         state_d;
  logic [3:0]     owed_q;
  logic [3:0]     owed_d;
  logic           clip;
  logic           dec;
  logic [5:0]     sum;
  logic           tmr_load;
  logic [TW-1:0]  tmr_val;
  logic           tmr_en;
  logic           tmr_done;

  cycle_timer #(
    .W (TW)
  ) u_timer (
    .clk_i      (clk),
    .rst_ni     (R),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .done_o     (tmr_done)
  );

  // Owed arithmetic: add requested coins, subtract an accepted ack, clamp at MAX_OWED
  always_comb begin
    dec    = (state_q == ST_REQ) && coin_ack && (owed_q != '0);
    sum    = 6'(owed_q) + 6'(ch_to_coins(ch)) - 6'(dec);
    clip   = 1'b0;
    owed_d = sum[3:0];
    if (sum > 6'(MAX_OWED)) begin
      owed_d = 4'(MAX_OWED);
      clip   = 1'b1;
    end
  end

  // Next-state and timer control, decided from the registered state and owed count
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (owed_q != '0) begin
          if (hopper_empty) begin
            state_d = ST_FAULT;
          end else begin
            state_d = ST_REQ;
`ifdef CHANGE_TIMEOUT_EN
            tmr_load = 1'b1;
            tmr_val  = ACK_LOAD;
`endif
          end
        end
      end
      ST_REQ: begin
        if (coin_ack) begin
          if (GAP_CYCLES == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d  = ST_GAP;
            tmr_load = 1'b1;
            tmr_val  = GAP_LOAD;
          end
`ifdef CHANGE_TIMEOUT_EN
        end else if (tmr_done) begin
          state_d = ST_FAULT;
        end else begin
          tmr_en = 1'b1;
`endif
        end
      end
      ST_GAP: begin
        if (tmr_done) begin
          state_d = ST_IDLE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_FAULT: begin
        if (fault_clr && !hopper_empty) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, owed count and all outputs registered together
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      state_q  <= ST_IDLE;
      owed_q   <= '0;
      coin_req <= 1'b0;
      busy     <= 1'b0;
      fault    <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      state_q  <= state_d;
      owed_q   <= owed_d;
      coin_req <= (state_d == ST_REQ);
      fault    <= (state_d == ST_FAULT);
      busy     <= (state_d != ST_IDLE) || (owed_d != '0);
      ovf      <= ovf | clip;
    end
  end

  assign owed = owed_q;

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - self-checking bench for change_dispenser with a behavioural model
module tb_change_dispenser;

  localparam int MAXO = 15;
  localparam int GAPC = 2;
  localparam int ACKT = 16;
`ifdef CHANGE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       R;
  logic [1:0] ch;
  logic       coin_req;
  logic       coin_ack;
  logic       hopper_empty;
  logic       fault_clr;
  logic [3:0] owed;
  logic       busy;
  logic       fault;
  logic       ovf;

  change_dispenser #(
    .MAX_OWED    (MAXO),
    .GAP_CYCLES  (GAPC),
    .ACK_TIMEOUT (ACKT)
  ) dut (
    .clk          (clk),
    .R            (R),
    .ch           (ch),
    .coin_req     (coin_req),
    .coin_ack     (coin_ack),
    .hopper_empty (hopper_empty),
    .fault_clr    (fault_clr),
    .owed         (owed),
    .busy         (busy),
    .fault        (fault),
    .ovf          (ovf)
  );

  always #5 clk = ~clk;

  // Behavioural model: a request flag, a gap countdown, a fault flag and a coin count
  int m_owed = 0;
  int m_n;
  int m_gap = 0;
  int m_age = 0;
  bit m_req = 0;
  bit m_fault = 0;
  bit m_ovf = 0;

  always @(posedge clk or negedge R) begin
    if (!R) begin
      m_owed = 0; m_gap = 0; m_age = 0;
      m_req = 0; m_fault = 0; m_ovf = 0;
    end else begin
      m_n = m_owed + int'(ch) - ((m_req && coin_ack) ? 1 : 0);
      if (m_n > MAXO) begin
        m_n = MAXO;
        m_ovf = 1;
      end
      if (m_n < 0) m_n = 0;
      if (m_req) begin
        if (coin_ack) begin
          m_req = 0;
          m_gap = GAPC;
        end else if (TO_EN) begin
          m_age = m_age + 1;
          if (m_age == ACKT) begin
            m_req = 0;
            m_fault = 1;
          end
        end
      end else if (m_gap > 0) begin
        m_gap = m_gap - 1;
      end else if (m_fault) begin
        if (fault_clr && !hopper_empty) m_fault = 0;
      end else if (m_owed > 0) begin
        if (hopper_empty) m_fault = 1;
        else begin
          m_req = 1;
          m_age = 0;
        end
      end
      m_owed = m_n;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Hopper responder and pulse bookkeeping state, all owned by the main process
  bit hop_en = 0;
  bit hop_spur = 0;
  int hop_delay = 2;
  int wait_c = 0;
  int pulses = 0;
  bit prev_req = 0;
  int low_run = 0;
  int min_low = 1000;
  bit seen = 0;

  task automatic clear_counts();
    pulses = 0; prev_req = coin_req; low_run = 0; min_low = 1000; seen = 0;
  endtask

  // One cycle: compare DUT against the model, count pulses, then act as the hopper
  task automatic tick();
    @(negedge clk);
    if (R) begin
      check("coin_req", int'(coin_req), int'(m_req));
      check("fault", int'(fault), int'(m_fault));
      check("owed", int'(owed), m_owed);
      check("busy", int'(busy), int'(m_req || m_fault || (m_gap > 0) || (m_owed > 0)));
      check("ovf", int'(ovf), int'(m_ovf));
      if (coin_req) begin
        if (!prev_req) begin
          pulses++;
          if (seen && low_run < min_low) min_low = low_run;
          seen = 1;
        end
        low_run = 0;
      end else begin
        low_run++;
      end
      prev_req = coin_req;
    end
    coin_ack = 1'b0;
    if (hop_en && coin_req) begin
      wait_c++;
      if (wait_c >= hop_delay) begin
        coin_ack = 1'b1;
        wait_c = 0;
      end
    end else begin
      wait_c = 0;
      if (hop_spur && !coin_req && $urandom_range(0, 7) == 0) coin_ack = 1'b1;
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    tick();
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check({name, "_idle_in_budget"}, int'(busy), 0);
  endtask

  initial begin
    R = 1'b0; ch = 2'b00; coin_ack = 1'b0; hopper_empty = 1'b0; fault_clr = 1'b0;
    repeat (3) tick();
    check("rst_owed", int'(owed), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_coin_req", int'(coin_req), 0);
    R = 1'b1;
    tick();
    check("post_rst_fault", int'(fault), 0);
    check("post_rst_ovf", int'(ovf), 0);

    // Single coin, ack two cycles after request
    hop_en = 1; hop_delay = 2; clear_counts();
    ch = 2'b01; tick(); ch = 2'b00;
    check("one_owed_after_ch", int'(owed), 1);
    wait_idle("one", 40);
    check("one_pulses", pulses, 1);
    check("one_owed_end", int'(owed), 0);

    // Three coins, then two more added while dispensing
    clear_counts();
    ch = 2'b11; tick(); ch = 2'b00;
    repeat (3) tick();
    ch = 2'b10; tick(); ch = 2'b00;
    wait_idle("five", 200);
    check("five_pulses", pulses, 5);
    check("five_min_gap_ge2", int'(min_low >= 2), 1);
    check("five_owed_end", int'(owed), 0);

    // Fill to 14, then saturate at 15 and drain
    hop_en = 0; clear_counts();
    ch = 2'b11; tick(); ch = 2'b11; tick(); ch = 2'b11; tick(); ch = 2'b11; tick();
    ch = 2'b10; tick();
    check("sat_owed14", int'(owed), 14);
    ch = 2'b11; tick(); ch = 2'b00;
    check("sat_owed15", int'(owed), 15);
    check("sat_ovf", int'(ovf), 1);
    hop_en = 1; hop_delay = 1;
    wait_idle("sat", 400);
    check("sat_pulses", pulses, 15);
    check("sat_owed_end", int'(owed), 0);

    // Empty hopper faults, acks ignored, then clear dispenses
    hopper_empty = 1; hop_spur = 1; clear_counts();
    ch = 2'b10; tick(); ch = 2'b00;
    repeat (6) tick();
    check("empty_fault", int'(fault), 1);
    check("empty_owed", int'(owed), 2);
    check("empty_pulses", pulses, 0);
    hop_spur = 0;
    hopper_empty = 0; fault_clr = 1; tick(); fault_clr = 0;
    wait_idle("empty", 100);
    check("empty_pulses_after_clr", pulses, 2);
    check("empty_fault_end", int'(fault), 0);

    // Request without ack: timeout fault or indefinite wait
    hop_en = 0; hop_delay = 2; clear_counts();
    ch = 2'b01; tick(); ch = 2'b00;
`ifdef CHANGE_TIMEOUT_EN
    repeat (25) tick();
    check("to_fault", int'(fault), 1);
    check("to_owed", int'(owed), 1);
    check("to_coin_req", int'(coin_req), 0);
    hop_en = 1; fault_clr = 1; tick(); fault_clr = 0;
    wait_idle("to", 100);
    check("to_pulses", pulses, 2);
`else
    repeat (99) tick();
    check("noto_coin_req_c100", int'(coin_req), 1);
    check("noto_owed", int'(owed), 1);
    hop_en = 1;
    wait_idle("noto", 100);
    check("noto_pulses", pulses, 1);
`endif

    // Reset mid-request abandons owed coins
    hop_en = 0;
    ch = 2'b11; tick(); ch = 2'b00;
    tick(); tick();
    check("mid_coin_req", int'(coin_req), 1);
    check("mid_owed", int'(owed), 3);
    @(posedge clk); #3;
    R = 1'b0;
    #1;
    check("mid_rst_coin_req", int'(coin_req), 0);
    check("mid_rst_owed", int'(owed), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_fault", int'(fault), 0);
    check("mid_rst_ovf", int'(ovf), 0);
    tick(); tick();
    R = 1'b1; hop_en = 1; clear_counts();
    repeat (20) tick();
    check("mid_after_pulses", pulses, 0);
    check("mid_after_coin_req", int'(coin_req), 0);

    // Randomised traffic against the model
    hop_spur = 1;
    for (int i = 0; i < 2000; i++) begin
      ch = ($urandom_range(0, 9) < 6) ? 2'b00 : 2'($urandom_range(1, 3));
      hopper_empty = ($urandom_range(0, 15) == 0);
      fault_clr = ($urandom_range(0, 3) == 0);
      hop_en = ($urandom_range(0, 19) != 0);
      hop_delay = $urandom_range(1, 3);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
